serial_frame_receiver: RTL and testbench
========================================

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits (>=2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 cs_n  input  1  conditioned chip select, active low.
REQ-005 sclk_rise  input  1  one-cycle pulse, conditioned serial-clock rising edge.
REQ-006 sclk_fall  input  1  one-cycle pulse, conditioned serial-clock falling edge.
REQ-007 mosi  input  1  conditioned serial data in, MSB first.
REQ-008 tx_data  input  WIDTH  word to send in the next frame.
REQ-009 tx_load  input  1  capture tx_data into tx_buf.
REQ-010 miso  output  1  registered serial data out, MSB first.
REQ-011 rx_data  output  WIDTH  last complete received word.
REQ-012 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-013 frame_error  output  1  one-cycle pulse, frame aborted early.
REQ-014 busy  output  1  high in SHIFT or HOLD.

Function
REQ-015 FSM states IDLE, SHIFT, HOLD; bit counter 0..WIDTH.
REQ-016 IDLE, cs_n=0 sampled -> SHIFT; bit_cnt<=0; tx_shift<=tx_buf; miso<=tx_buf[WIDTH-1].
REQ-017 Edge pulses in the IDLE->SHIFT transition cycle ignored.
REQ-018 SHIFT, sclk_rise: rx_shift<={rx_shift[WIDTH-2:0],mosi}; bit_cnt+1.
REQ-019 SHIFT, sclk_fall with 1<=bit_cnt<=WIDTH-1: tx_shift shifts left one; miso<=next bit (tx_shift[WIDTH-2]).
REQ-020 sclk_fall with bit_cnt=0 ignored (first bit already driven).
REQ-021 sclk_rise and sclk_fall in same cycle: rise processed, fall ignored.
REQ-022 On the clk edge sampling the WIDTH-th sclk_rise: rx_data<=completed word, rx_valid=1 following cycle for exactly one cycle, state->HOLD.
REQ-023 HOLD: all sclk edges and mosi ignored; miso=0; cs_n=1 -> IDLE, no error.
REQ-024 SHIFT, cs_n=1 sampled (bit_cnt<WIDTH): frame_error pulse one cycle, rx_data unchanged, rx_valid not asserted, ->IDLE.
REQ-025 cs_n=1 and WIDTH-th sclk_rise same cycle: frame completes (REQ-022), then IDLE next cycle; no frame_error.
REQ-026 tx_load in any state: tx_buf<=tx_data next edge; does not alter frame in progress; used at next IDLE->SHIFT.
REQ-027 tx_load same cycle as IDLE->SHIFT: new tx_data sent in that frame.
REQ-028 miso=0 in IDLE and HOLD; rx_valid and frame_error never high same cycle.
REQ-029 Back-to-back frames need cs_n high at least one clk cycle between them.

Reset
REQ-030 resetn=0 on clk edge: state IDLE, bit_cnt=0, tx_buf=0, tx_shift=0, rx_shift=0, rx_data=0, miso=0, rx_valid=0, frame_error=0, busy=0.
REQ-031 Reset mid-frame aborts silently: no frame_error, no rx_valid.
REQ-032 Reset overrides all inputs in the same cycle.

Verification
REQ-033 tx_load with tx_data=8'hA5, cs_n low, 8 rise/fall pairs with mosi=0x3C -> rx_data=8'h3C, one rx_valid pulse, miso sequence 1,0,1,0,0,1,0,1.
REQ-034 cs_n high after 5 rises -> one frame_error pulse, rx_data retains prior 8'h3C, busy=0 next cycle.
REQ-035 Extra 3 rises in HOLD after full frame with mosi=1 -> rx_data unchanged, no second rx_valid.
REQ-036 tx_load 8'hFF mid-frame sending 8'h00 -> current miso all 0; next frame miso all 1.
REQ-037 resetn=0 after 4 rises -> all outputs 0, no pulses; new full frame 8'h81 received correctly afterwards.
REQ-038 cs_n rise coincident with 8th sclk_rise, mosi frame 8'hC3 -> rx_valid once, rx_data=8'hC3, frame_error stays 0.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   SPI-style slave frame engine. Serial clock edges and chip select come in
//   already conditioned (synchronised, edge-detected) in the clk domain.
//   One frame = WIDTH bits, MSB first on both mosi and miso.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   resetn       synchronous active-low reset
//   cs_n         chip select, active low
//   sclk_rise    one-cycle pulse: serial clock rising edge (sample mosi)
//   sclk_fall    one-cycle pulse: serial clock falling edge (advance miso)
//   mosi         serial data in
//   tx_data      word to transmit in the next frame
//   tx_load      capture tx_data into the transmit buffer
//   miso         registered serial data out (0 outside SHIFT)
//   rx_data      last completely received word
//   rx_valid     one-cycle pulse, rx_data just updated
//   frame_error  one-cycle pulse, chip select released mid-frame
//   busy         high while in SHIFT or HOLD
module serial_frame_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cs_n,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic             mosi,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] tx_buf_reg, tx_buf_next;
  logic [WIDTH-1:0] tx_shift_reg, tx_shift_next;
  logic [WIDTH-1:0] rx_shift_reg, rx_shift_next;
  logic [WIDTH-1:0] rx_data_reg, rx_data_next;
  logic             miso_reg, miso_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             frame_error_reg, frame_error_next;

  // A load in the same cycle as frame start must already be visible to that
  // frame, so bypass the buffer register here.
  logic [WIDTH-1:0] tx_start_word;
  assign tx_start_word = tx_load ? tx_data : tx_buf_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      tx_buf_reg      <= '0;
      tx_shift_reg    <= '0;
      rx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      miso_reg        <= 1'b0;
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      tx_buf_reg      <= tx_buf_next;
      tx_shift_reg    <= tx_shift_next;
      rx_shift_reg    <= rx_shift_next;
      rx_data_reg     <= rx_data_next;
      miso_reg        <= miso_next;
      rx_valid_reg    <= rx_valid_next;
      frame_error_reg <= frame_error_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    tx_buf_next      = tx_load ? tx_data : tx_buf_reg;
    tx_shift_next    = tx_shift_reg;
    rx_shift_next    = rx_shift_reg;
    rx_data_next     = rx_data_reg;
    miso_next        = miso_reg;
    rx_valid_next    = 1'b0;
    frame_error_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        miso_next = 1'b0;
        // Edge pulses in the start cycle are deliberately dropped.
        if (!cs_n) begin
          state_next    = SHIFT;
          bit_cnt_next  = '0;
          tx_shift_next = tx_start_word;
          miso_next     = tx_start_word[WIDTH-1];
        end
      end

      SHIFT: begin
        if (sclk_rise && bit_cnt_reg == LAST_BIT) begin
          // Final bit wins over a coincident cs_n release: frame is good.
          rx_shift_next = {rx_shift_reg[WIDTH-2:0], mosi};
          rx_data_next  = {rx_shift_reg[WIDTH-2:0], mosi};
          rx_valid_next = 1'b1;
          bit_cnt_next  = FULL_CNT;
          miso_next     = 1'b0;
          state_next    = HOLD;
        end else if (cs_n) begin
          frame_error_next = 1'b1;
          miso_next        = 1'b0;
          state_next       = IDLE;
        end else if (sclk_rise) begin
          // A fall arriving with the rise is ignored.
          rx_shift_next = {rx_shift_reg[WIDTH-2:0], mosi};
          bit_cnt_next  = bit_cnt_reg + 1'b1;
        end else if (sclk_fall && bit_cnt_reg != '0 && bit_cnt_reg < FULL_CNT) begin
          // Fall before the first rise is ignored: the MSB went out at start.
          tx_shift_next = {tx_shift_reg[WIDTH-2:0], 1'b0};
          miso_next     = tx_shift_reg[WIDTH-2];
        end
      end

      HOLD: begin
        miso_next = 1'b0;
        if (cs_n) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        miso_next  = 1'b0;
      end
    endcase
  end

  assign miso        = miso_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_error = frame_error_reg;
  assign busy        = (state_reg == SHIFT) || (state_reg == HOLD);

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk_rise = 1'b0;
  logic       sclk_fall = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int passed = 0;
  int rxv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic [7:0] miso_seq;

  serial_frame_receiver #(.WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .cs_n(cs_n), .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall), .mosi(mosi), .tx_data(tx_data), .tx_load(tx_load),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (frame_error) fe_cnt++;
    if (rx_valid && frame_error) both_cnt++;
  end

  // Advance one clock; outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rise/fall pair; miso is recorded just before the rise.
  task automatic sclk_pair(input int idx, input logic m);
    miso_seq[7-idx] = miso;
    mosi = m;
    sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
    tick();
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
    tick();
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic load_tx(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else passed++;
    checks++; if (miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", miso); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); else passed++;
    checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error got=%b exp=0", frame_error); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    resetn = 1'b1;
    tick();
    $display("reset: rx_data=%h busy=%b", rx_data, busy);
  endtask

  task automatic test_basic();
    int rv0;
    logic [7:0] w;
    w = 8'h3C;
    load_tx(8'hA5);
    rv0 = rxv_cnt;
    start_frame();
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else passed++;
    for (int i = 0; i < 8; i++) sclk_pair(i, w[7-i]);
    checks++; if (rx_data !== 8'h3C) $display("FAIL basic_rx_data got=%h exp=3c", rx_data); else passed++;
    checks++; if (miso_seq !== 8'hA5) $display("FAIL basic_miso_seq got=%h exp=a5", miso_seq); else passed++;
    checks++; if (miso !== 1'b0) $display("FAIL basic_hold_miso got=%b exp=0", miso); else passed++;
    end_frame();
    checks++; if (rxv_cnt - rv0 !== 1) $display("FAIL basic_rx_valid_pulses got=%0d exp=1", rxv_cnt - rv0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got=%b exp=0", busy); else passed++;
    $display("basic frame: rx=%h miso_seq=%h", rx_data, miso_seq);
  endtask

  task automatic test_abort();
    int rv0, fe0;
    rv0 = rxv_cnt;
    fe0 = fe_cnt;
    start_frame();
    for (int i = 0; i < 5; i++) sclk_pair(i, 1'b1);
    cs_n = 1'b1;
    tick();
    checks++; if (frame_error !== 1'b1) $display("FAIL abort_frame_error got=%b exp=1", frame_error); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    tick();
    checks++; if (frame_error !== 1'b0) $display("FAIL abort_pulse_width got=%b exp=0", frame_error); else passed++;
    checks++; if (fe_cnt - fe0 !== 1) $display("FAIL abort_fe_pulses got=%0d exp=1", fe_cnt - fe0); else passed++;
    checks++; if (rxv_cnt - rv0 !== 0) $display("FAIL abort_rx_valid_pulses got=%0d exp=0", rxv_cnt - rv0); else passed++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL abort_rx_data got=%h exp=3c", rx_data); else passed++;
    $display("aborted frame: rx=%h", rx_data);
  endtask

  task automatic test_hold();
    int rv0;
    logic [7:0] w;
    w = 8'h5A;
    rv0 = rxv_cnt;
    start_frame();
    for (int i = 0; i < 8; i++) sclk_pair(i, w[7-i]);
    for (int i = 0; i < 3; i++) sclk_pair(0, 1'b1);
    end_frame();
    checks++; if (rx_data !== 8'h5A) $display("FAIL hold_rx_data got=%h exp=5a", rx_data); else passed++;
    checks++; if (rxv_cnt - rv0 !== 1) $display("FAIL hold_rx_valid_pulses got=%0d exp=1", rxv_cnt - rv0); else passed++;
    $display("hold frame: rx=%h", rx_data);
  endtask

  task automatic test_tx_load_mid();
    load_tx(8'h00);
    start_frame();
    for (int i = 0; i < 3; i++) sclk_pair(i, 1'b0);
    load_tx(8'hFF);
    for (int i = 3; i < 8; i++) sclk_pair(i, 1'b1);
    end_frame();
    checks++; if (miso_seq !== 8'h00) $display("FAIL txmid_cur_miso got=%h exp=00", miso_seq); else passed++;
    checks++; if (rx_data !== 8'h1F) $display("FAIL txmid_rx_data got=%h exp=1f", rx_data); else passed++;
    start_frame();
    for (int i = 0; i < 8; i++) sclk_pair(i, 1'b0);
    end_frame();
    checks++; if (miso_seq !== 8'hFF) $display("FAIL txmid_next_miso got=%h exp=ff", miso_seq); else passed++;
    $display("tx load mid-frame: next miso_seq=%h", miso_seq);
  endtask

  task automatic test_reset_mid();
    int rv0, fe0;
    logic [7:0] w;
    w = 8'h81;
    load_tx(8'hC0);
    rv0 = rxv_cnt;
    fe0 = fe_cnt;
    start_frame();
    for (int i = 0; i < 4; i++) sclk_pair(i, 1'b1);
    resetn = 1'b0;
    tick();
    checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    checks++; if (miso !== 1'b0) $display("FAIL rstmid_miso got=%b exp=0", miso); else passed++;
    resetn = 1'b1;
    cs_n = 1'b1;
    tick();
    tick();
    checks++; if (fe_cnt - fe0 !== 0) $display("FAIL rstmid_fe_pulses got=%0d exp=0", fe_cnt - fe0); else passed++;
    checks++; if (rxv_cnt - rv0 !== 0) $display("FAIL rstmid_rxv_pulses got=%0d exp=0", rxv_cnt - rv0); else passed++;
    start_frame();
    for (int i = 0; i < 8; i++) sclk_pair(i, w[7-i]);
    end_frame();
    checks++; if (rx_data !== 8'h81) $display("FAIL rstmid_new_rx got=%h exp=81", rx_data); else passed++;
    checks++; if (miso_seq !== 8'h00) $display("FAIL rstmid_txbuf_cleared got=%h exp=00", miso_seq); else passed++;
    $display("reset mid-frame then frame: rx=%h", rx_data);
  endtask

  task automatic test_coincident();
    int rv0, fe0;
    logic [7:0] w;
    w = 8'hC3;
    rv0 = rxv_cnt;
    fe0 = fe_cnt;
    start_frame();
    for (int i = 0; i < 7; i++) sclk_pair(i, w[7-i]);
    mosi = w[0];
    sclk_rise = 1'b1;
    cs_n = 1'b1;
    tick();
    sclk_rise = 1'b0;
    checks++; if (rx_valid !== 1'b1) $display("FAIL coinc_rx_valid got=%b exp=1", rx_valid); else passed++;
    checks++; if (rx_data !== 8'hC3) $display("FAIL coinc_rx_data got=%h exp=c3", rx_data); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL coinc_hold_busy got=%b exp=1", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL coinc_idle_busy got=%b exp=0", busy); else passed++;
    tick();
    checks++; if (fe_cnt - fe0 !== 0) $display("FAIL coinc_fe_pulses got=%0d exp=0", fe_cnt - fe0); else passed++;
    checks++; if (rxv_cnt - rv0 !== 1) $display("FAIL coinc_rxv_pulses got=%0d exp=1", rxv_cnt - rv0); else passed++;
    $display("coincident end frame: rx=%h", rx_data);
  endtask

  task automatic test_back_to_back();
    // Load in the start cycle is used by that frame; rise+fall together drop the fall.
    tx_data = 8'h69;
    tx_load = 1'b1;
    cs_n = 1'b0;
    tick();
    tx_load = 1'b0;
    checks++; if (miso !== 1'b0) $display("FAIL b2b_start_miso got=%b exp=0", miso); else passed++;
    mosi = 1'b1;
    sclk_rise = 1'b1;
    sclk_fall = 1'b1;
    tick();
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    checks++; if (miso !== 1'b0) $display("FAIL b2b_fall_ignored got=%b exp=0", miso); else passed++;
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
    checks++; if (miso !== 1'b1) $display("FAIL b2b_second_bit got=%b exp=1", miso); else passed++;
    for (int i = 1; i < 8; i++) sclk_pair(i, 1'b0);
    end_frame();
    checks++; if (rx_data !== 8'h80) $display("FAIL b2b_rx_data got=%h exp=80", rx_data); else passed++;
    checks++; if (both_cnt !== 0) $display("FAIL excl_pulses got=%0d exp=0", both_cnt); else passed++;
    $display("back-to-back frame: rx=%h", rx_data);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_hold();
    test_tx_load_mid();
    test_reset_mid();
    test_coincident();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
